// File: rtl/shifter_row_reader.sv
// Sequencer that loads one row into a DEPTH-entry row shifter, then replays it as overlapping
// TILE-wide windows (STRIDE apart) on a valid/ready stream. Optional macro: SHIFTER_READER_STALL_CNT_EN.
module shifter_row_reader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int TILE   = 4,
  parameter int STRIDE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sh_enable,
  output logic [DATA_W-1:0] sh_data,
  output logic [7:0]        sh_index,
  input  logic [DATA_W-1:0] sh_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              row_done,
  output logic [15:0]       stall_cnt
);

  localparam int NWIN  = (DEPTH - TILE) / STRIDE + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(TILE - 1);
  localparam logic [CNT_W-1:0] LAST_WIN  = CNT_W'(NWIN - 1);
  localparam logic [7:0]       FULL_IDX  = 8'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_READ
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] elem_cnt, elem_nxt;
  logic [CNT_W-1:0] win_cnt, win_nxt;
  logic [7:0]       idx_nxt;
  logic             pix_take;
  logic             accept;
  logic             row_end;

  assign in_ready = (state == S_FILL);
  assign out_data = sh_rdata;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    pix_take  = in_valid & in_ready;
    accept    = out_valid & out_ready;
    row_end   = (state == S_READ) && accept &&
                (elem_cnt == LAST_ELEM) && (win_cnt == LAST_WIN);
    elem_nxt  = elem_cnt + 1'b1;
    win_nxt   = win_cnt;
    if (elem_cnt == LAST_ELEM) begin
      elem_nxt = '0;
      win_nxt  = win_cnt + 1'b1;
    end
    // Window w, element e reads pixel w*STRIDE+e, which sits at index DEPTH-(w*STRIDE+e).
    idx_nxt   = 8'(DEPTH - (int'(win_nxt) * STRIDE + int'(elem_nxt)));

    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_FILL;
      S_FILL:  if (pix_take && (pix_cnt == LAST_PIX)) state_nxt = S_READ;
      S_READ:  if (row_end) state_nxt = en ? S_FILL : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt   <= '0;
      elem_cnt  <= '0;
      win_cnt   <= '0;
      sh_enable <= 1'b0;
      sh_data   <= '0;
      sh_index  <= FULL_IDX;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      row_done  <= 1'b0;
    end else begin
      sh_enable <= 1'b0;
      row_done  <= 1'b0;
      case (state)
        S_FILL: begin
          if (pix_take) begin
            sh_data   <= in_data;
            sh_enable <= 1'b1;
            pix_cnt   <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (!out_valid) begin
            // First READ cycle: the last shift has landed, so the first element is readable now.
            out_valid <= 1'b1;
            sh_index  <= FULL_IDX;
            elem_cnt  <= '0;
            win_cnt   <= '0;
            out_last  <= (LAST_ELEM == '0);
          end else if (out_ready) begin
            if (row_end) begin
              out_valid <= 1'b0;
              row_done  <= 1'b1;
              out_last  <= 1'b0;
              elem_cnt  <= '0;
              win_cnt   <= '0;
              sh_index  <= FULL_IDX;
            end else begin
              elem_cnt  <= elem_nxt;
              win_cnt   <= win_nxt;
              sh_index  <= idx_nxt;
              out_last  <= (elem_nxt == LAST_ELEM);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFTER_READER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (row_end) begin
      stall_q <= '0;
    end else if ((state == S_READ) && out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_shifter_row_reader.sv
// Bench for shifter_row_reader: a behavioural row shifter plus a window-sequence model built from
// the accepted pixels; random fill gaps and random downstream backpressure.
module tb_shifter_row_reader;

  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int TILE   = 4;
  localparam int STRIDE = 2;
  localparam int NWIN   = (DEPTH - TILE) / STRIDE + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          sh_enable;
  logic [DW-1:0] sh_data;
  logic [7:0]    sh_index;
  logic [DW-1:0] sh_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          row_done;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  shifter_row_reader #(.DATA_W(DW), .DEPTH(DEPTH), .TILE(TILE), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sh_enable(sh_enable), .sh_data(sh_data), .sh_index(sh_index), .sh_rdata(sh_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .row_done(row_done), .stall_cnt(stall_cnt)
  );

  // Row shifter: new pixel enters entry 0, older ones move up; data_out is entry index-1.
  logic [DW-1:0] shreg [DEPTH];
  always @(posedge clk) begin
    if (sh_enable) begin
      for (int i = DEPTH - 1; i > 0; i--) shreg[i] <= shreg[i-1];
      shreg[0] <= sh_data;
    end
  end

  always_comb begin
    int i;
    i = int'(sh_index) - 1;
    sh_rdata = (i >= 0 && i < DEPTH) ? shreg[i] : '0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [7:0]    idx;
    logic          fin;
  } elem_t;

  elem_t         exp_q[$];
  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] row_buf [DEPTH];
  int            fill_n      = 0;
  int            lat_cnt     = -1;
  bit            rd_active   = 0;
  bit            expect_done = 0;
  int            stall_exp   = 0;
  int            row_acc     = 0;
  int            rows_done   = 0;
  int            sh_en_cnt   = 0;

  // Monitor: samples on the falling edge, between the driver's updates and the DUT's capture edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      exp_q.delete();
      fill_n      = 0;
      lat_cnt     = -1;
      rd_active   = 0;
      expect_done = 0;
      stall_exp   = 0;
      row_acc     = 0;
    end else begin
      if (lat_cnt >= 0) lat_cnt++;

      if (sh_enable) begin
        sh_en_cnt++;
        if (acc_q.size() == 0) check("sh_enable_spurious", 1, 0);
        else                   check("sh_data", sh_data, acc_q.pop_front());
      end

      check("row_done", row_done, expect_done);
      if (expect_done) rows_done++;
      expect_done = 0;

      check("stall_cnt", stall_cnt, stall_exp);

      if (!rd_active && out_valid) begin
        check("first_valid_latency", lat_cnt, 2);
        rd_active = 1;
        lat_cnt   = -1;
      end

      if (rd_active || lat_cnt > 0) check("in_ready_low", in_ready, 0);
      if (rd_active) check("sh_index_range", (sh_index >= 1 && sh_index <= DEPTH), 1);

      if (rd_active) begin
        check("out_valid_no_bubble", out_valid, 1);
        if (exp_q.size() == 0) begin
          check("out_extra", 1, 0);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_last", out_last, exp_q[0].last);
          check("sh_index", sh_index, exp_q[0].idx);
          if (out_ready) begin
            row_acc++;
            if (exp_q[0].fin) begin
              expect_done = 1;
              rd_active   = 0;
              stall_exp   = 0;
              row_acc     = 0;
            end
            void'(exp_q.pop_front());
          end else begin
`ifdef SHIFTER_READER_STALL_CNT_EN
            stall_exp++;
`endif
          end
        end
      end

      if (in_valid && in_ready) begin
        acc_q.push_back(in_data);
        row_buf[fill_n] = in_data;
        fill_n++;
        if (fill_n == DEPTH) begin
          // Window w element e is pixel w*STRIDE+e of the row, read at index DEPTH-(w*STRIDE+e).
          for (int w = 0; w < NWIN; w++)
            for (int e = 0; e < TILE; e++)
              exp_q.push_back('{data: row_buf[w*STRIDE+e], last: (e == TILE - 1),
                                idx: 8'(DEPTH - (w*STRIDE + e)),
                                fin: (w == NWIN - 1 && e == TILE - 1)});
          fill_n  = 0;
          lat_cnt = 0;
        end
      end
    end
  end

  logic [DW-1:0] row_px [DEPTH];

  task automatic fill_row(input int max_gap);
    for (int k = 0; k < DEPTH; k++) begin
      int  t;
      bit  acc;
      repeat ($urandom_range(max_gap, 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = row_px[k];
      t   = 0;
      acc = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) check("fill_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_row(input int pct, input int stop_at);
    int start;
    int t;
    start = rows_done;
    t     = 0;
    while (rows_done == start && row_acc < stop_at && t < 3000) begin
      @(posedge clk); #1;
      out_ready = (int'($urandom_range(99, 0)) < pct);
      t++;
    end
    if (t >= 3000) check("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_sh_enable"}, sh_enable, 0);
    check({tag, "_sh_data"},   sh_data,   0);
    check({tag, "_sh_index"},  sh_index,  DEPTH);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_row_done"},  row_done,  0);
    check({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    int sh0;
    rst_n     = 1'b0;
    en        = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // T1: async reset mid-cycle while pixels are flowing into the shifter.
    en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 16'h00A0 + 16'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t1_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // T2/T3: pixels 1..16 back-to-back, full-throughput readout.
    for (int k = 0; k < DEPTH; k++) row_px[k] = 16'(k + 1);
    sh0 = sh_en_cnt;
    out_ready = 1'b1;
    fill_row(0);
    drain_row(100, 1000);
    repeat (2) begin @(posedge clk); #1; end
    check("t3_sh_enable_count", sh_en_cnt - sh0, DEPTH);
    check("t3_rows_done", rows_done, 1);

    // T4: random pixels with ~50% downstream backpressure.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < DEPTH; k++) row_px[k] = 16'($urandom);
      out_ready = 1'b0;
      fill_row(0);
      drain_row(50, 1000);
    end
    repeat (2) begin @(posedge clk); #1; end
    check("t4_rows_done", rows_done, 3);

    // T5: bubbly input stream.
    for (int k = 0; k < DEPTH; k++) row_px[k] = 16'($urandom);
    sh0 = sh_en_cnt;
    out_ready = 1'b1;
    fill_row(3);
    drain_row(100, 1000);
    repeat (2) begin @(posedge clk); #1; end
    check("t5_sh_enable_count", sh_en_cnt - sh0, DEPTH);

    // T6: reset during READ after 10 accepted elements, then a fresh row 101..116.
    for (int k = 0; k < DEPTH; k++) row_px[k] = 16'($urandom);
    fill_row(1);
    drain_row(70, 10);
    check("t6_abort_point", row_acc, 10);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) row_px[k] = 16'(101 + k);
    out_ready = 1'b0;
    fill_row(0);
    // en dropped during the row: the row still completes, then the reader parks in IDLE.
    en = 1'b0;
    drain_row(70, 1000);
    repeat (4) begin @(posedge clk); #1; end
    check("t6_rows_done", rows_done, 5);
    check("idle_in_ready", in_ready, 0);
    check("idle_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
